serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port clk input 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst input 1: synchronous, active-high reset.
REQ-004 SHALL have port start input 1: request a new operation; sampled on the rising edge of clk.
REQ-005 SHALL have port mode input 1: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 SHALL have port a input WIDTH: first operand; sampled with start.
REQ-007 SHALL have port b input WIDTH: second operand; sampled with start.
REQ-008 SHALL have port busy output 1: high while the operation is in progress.
REQ-009 SHALL have port done output 1: one-cycle pulse marking the result as valid.
REQ-010 SHALL have port result output WIDTH: sum or difference.
REQ-011 SHALL have port cout output 1: carry out of the MSB; for subtract, 1 = no borrow (a >= b unsigned).
REQ-012 SHALL have port overflow output 1: two's-complement signed overflow flag.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL accept start only in IDLE or DONE, so back-to-back operations are allowed; start in RUN SHALL be ignored.
REQ-015 On an accepted start, SHALL:
- latch a into shift register SA;
- latch b XOR {WIDTH{mode}} into SB;
- set the internal carry to mode;
- clear the bit counter;
- enter RUN.
REQ-016 In RUN, each cycle SHALL apply one full-adder step to SA[0], SB[0] and carry:
- shift the sum bit into the MSB of an internal accumulator;
- right-shift SA and SB;
- update carry;
- increment the counter.
REQ-017 SHALL record the carry into the MSB, i.e. the carry-in of step WIDTH-1, for overflow computation.
REQ-018 After exactly WIDTH RUN cycles, SHALL enter DONE.
REQ-019 On entering DONE, SHALL load the output registers:
- result = accumulator;
- cout = final carry;
- overflow = final carry XOR carry into MSB.
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE unless a start is accepted in that cycle.
REQ-021 busy SHALL equal (state == RUN); done SHALL equal (state == DONE).
REQ-022 Timing: start sampled at edge k gives busy = 1 after edges k..k+WIDTH-1 (WIDTH cycles) and done = 1 for the single cycle after edge k+WIDTH.
REQ-023 result, cout and overflow SHALL hold their previous values while busy and remain stable from done until the next DONE entry.
REQ-024 Changes on a, b and mode after acceptance SHALL have no effect on the operation in progress.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; result SHALL equal (a + b) or (a - b) mod 2^WIDTH.
REQ-026 WIDTH = 1 SHALL work: one RUN cycle, and overflow is computed with carry-in = mode.

Reset
REQ-027 While rst = 1, the block SHALL go to IDLE and clear SA, SB, carry, counter and accumulator.
REQ-028 While rst = 1, outputs SHALL be busy = 0, done = 0, result = 0, cout = 0, overflow = 0.
REQ-029 rst SHALL take priority over start.
REQ-030 Reset during RUN SHALL abort the operation with no done pulse and zeroed outputs.

Verification (WIDTH = 8 unless stated)
REQ-031 add a=8'h25, b=8'h1A -> busy 8 cycles, then done 1 cycle; result = 8'h3F, cout = 0, overflow = 0.
REQ-032 add 8'hFF + 8'h01 -> result 8'h00, cout = 1, overflow = 0; add 8'h7F + 8'h01 -> result 8'h80, cout = 0, overflow = 1.
REQ-033 sub 8'h05 - 8'h07 -> result 8'hFE, cout = 0, overflow = 0; sub 8'h80 - 8'h01 -> result 8'h7F, cout = 1, overflow = 1.
REQ-034 WIDTH = 1, all 8 combinations of a, b, mode in order 000..111 -> each done after 1 busy cycle, result/cout matching the full-adder truth table with b inverted and carry-in = mode.
REQ-035 start in the DONE cycle with new operands -> busy reasserts next cycle, the second result is correct, and the first result is held until the second done.
REQ-036 Mid-operation events -> rst on the 4th busy cycle: busy = 0, no done, all outputs 0; start pulsed in RUN (a separate run): ignored, and the original result is unaffected.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Subtract is a + ~b + 1; flags are registered when the last bit retires.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_sum;
  logic             w_carry;
  logic             w_last;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_acc_next;

  assign w_sum   = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_carry = (r_sa[0] & r_sb[0]) | (r_carry & (r_sa[0] ^ r_sb[0]));
  assign w_last  = (r_cnt == LAST);
  // On the final step the live carry is the carry into the MSB.
  assign w_cmsb  = r_carry;

  generate
    if (WIDTH == 1) begin : g_acc1
      assign w_acc_next = w_sum;
    end else begin : g_accn
      assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b ^ {WIDTH{mode}};
            r_carry <= mode;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_state  <= DONE;
            r_result <= w_acc_next;
            r_cout   <= w_carry;
            r_ovf    <= w_carry ^ w_cmsb;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
